// File: rtl/plat_pkg.sv
// Shared definitions for the platform landing scan: table geometry, character
// hitbox constants, FSM state encoding and packed-bus field extraction helpers.
package plat_pkg;

  localparam int PLATFORM_NUM_PER_BLOCK = 7;
  localparam int PHY_WIDTH              = 16;
  localparam int BLOCK_LEN_WIDTH        = 4;
  localparam int PLAT_UNIT              = 8;
  localparam int PLAT_SHIFT             = $clog2(PLAT_UNIT);
  localparam int CHAR_W                 = 32;
  localparam int LAND_TOL               = 8;
  localparam int IDX_WIDTH              = 3;

  typedef logic [PHY_WIDTH-1:0]       phy_t;
  typedef logic [PHY_WIDTH:0]         phy_ext_t;
  typedef logic [BLOCK_LEN_WIDTH-1:0] len_t;
  typedef logic [IDX_WIDTH-1:0]       idx_t;

  typedef logic [PLATFORM_NUM_PER_BLOCK*PHY_WIDTH-1:0]       phy_bus_t;
  typedef logic [PLATFORM_NUM_PER_BLOCK*BLOCK_LEN_WIDTH-1:0] len_bus_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } scan_state_e;

  localparam idx_t LAST_IDX = idx_t'(PLATFORM_NUM_PER_BLOCK - 1);

  // Left x of platform i from the packed x bus
  function automatic phy_t get_x(input phy_bus_t bus, input idx_t i);
    return bus[int'(i)*PHY_WIDTH +: PHY_WIDTH];
  endfunction

  // Top y of platform i from the packed y bus
  function automatic phy_t get_y(input phy_bus_t bus, input idx_t i);
    return bus[int'(i)*PHY_WIDTH +: PHY_WIDTH];
  endfunction

  // Length (in units) of platform i from the packed length bus
  function automatic len_t get_len(input len_bus_t bus, input idx_t i);
    return bus[int'(i)*BLOCK_LEN_WIDTH +: BLOCK_LEN_WIDTH];
  endfunction

endpackage

// File: rtl/plat_hit_cmp.sv
// Single-entry landing test: does the falling character's hitbox land on one
// platform? All sums are formed one bit wider than the coordinates so that
// edges near the top of the coordinate range cannot wrap.
module plat_hit_cmp
  import plat_pkg::*;
(
  input  logic [PHY_WIDTH-1:0]       cx,
  input  logic [PHY_WIDTH-1:0]       cy,
  input  logic                       falling,
  input  logic [PHY_WIDTH-1:0]       px,
  input  logic [PHY_WIDTH-1:0]       py,
  input  logic [BLOCK_LEN_WIDTH-1:0] len,
  output logic                       hit
);

  phy_ext_t cx_e_s;
  phy_ext_t cy_e_s;
  phy_ext_t px_e_s;
  phy_ext_t py_e_s;
  phy_ext_t top_tol_s;
  phy_ext_t char_right_s;
  phy_ext_t plat_right_s;

  // Widen operands, build the landing window and evaluate all conditions
  always_comb begin
    cx_e_s       = {1'b0, cx};
    cy_e_s       = {1'b0, cy};
    px_e_s       = {1'b0, px};
    py_e_s       = {1'b0, py};
    top_tol_s    = py_e_s + phy_ext_t'(LAND_TOL);
    char_right_s = cx_e_s + phy_ext_t'(CHAR_W);
    plat_right_s = px_e_s + (phy_ext_t'(len) << PLAT_SHIFT);
    hit = falling
          && (len != {BLOCK_LEN_WIDTH{1'b0}})
          && (cy_e_s >= py_e_s)
          && (cy_e_s <= top_tol_s)
          && (char_right_s > px_e_s)
          && (cx_e_s < plat_right_s);
  end

endmodule

// File: rtl/platform_scan_ctrl.sv
// Sequential landing scheduler: on each physics tick walks the platform table
// one entry per cycle through a single plat_hit_cmp, keeps the highest hit
// (lowest index on ties) and publishes it with a one-cycle scan_done pulse.
// A block_switch during the walk restarts it against the new table.
module platform_scan_ctrl
  import plat_pkg::*;
(
  input  logic                                              sys_clk,
  input  logic                                              sys_rst_n,
  input  logic                                              scan_start,
  input  logic [PHY_WIDTH-1:0]                              char_x,
  input  logic [PHY_WIDTH-1:0]                              char_y,
  input  logic                                              char_falling,
  input  logic [PLATFORM_NUM_PER_BLOCK*PHY_WIDTH-1:0]       plat_relative_x,
  input  logic [PLATFORM_NUM_PER_BLOCK*PHY_WIDTH-1:0]       plat_relative_y,
  input  logic [PLATFORM_NUM_PER_BLOCK*BLOCK_LEN_WIDTH-1:0] plat_len,
  input  logic                                              block_switch,
  output logic                                              busy,
  output logic                                              scan_done,
  output logic                                              land_hit,
  output logic [2:0]                                        land_idx,
  output logic [PHY_WIDTH-1:0]                              land_y
);

  scan_state_e state_r, state_nxt_s;
  idx_t        idx_r, idx_nxt_s;
  phy_t        cx_r, cy_r;
  logic        fall_r;
  logic        best_hit_r, best_hit_nxt_s;
  idx_t        best_idx_r, best_idx_nxt_s;
  phy_t        best_y_r, best_y_nxt_s;
  logic        latch_s;
  logic        finish_s;
  phy_t        px_s, py_s;
  len_t        len_s;
  logic        hit_s;
  logic        busy_r, scan_done_r, land_hit_r;
  idx_t        land_idx_r;
  phy_t        land_y_r;

  // Select the entry currently under test from the live platform buses
  always_comb begin
    px_s  = get_x(plat_relative_x, idx_r);
    py_s  = get_y(plat_relative_y, idx_r);
    len_s = get_len(plat_len, idx_r);
  end

  plat_hit_cmp u_hit_cmp (
    .cx      (cx_r),
    .cy      (cy_r),
    .falling (fall_r),
    .px      (px_s),
    .py      (py_s),
    .len     (len_s),
    .hit     (hit_s)
  );

  // Next-state, index, best-hit tracking and capture/finish strobes
  always_comb begin
    state_nxt_s    = state_r;
    idx_nxt_s      = idx_r;
    best_hit_nxt_s = best_hit_r;
    best_idx_nxt_s = best_idx_r;
    best_y_nxt_s   = best_y_r;
    latch_s        = 1'b0;
    finish_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (scan_start) begin
          latch_s        = 1'b1;
          idx_nxt_s      = 3'd0;
          best_hit_nxt_s = 1'b0;
          best_idx_nxt_s = 3'd0;
          best_y_nxt_s   = {PHY_WIDTH{1'b0}};
          state_nxt_s    = ST_SCAN;
        end else begin
          state_nxt_s    = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (block_switch) begin
          // New table arriving: discard partial result, keep the latched character
          idx_nxt_s      = 3'd0;
          best_hit_nxt_s = 1'b0;
          best_idx_nxt_s = 3'd0;
          best_y_nxt_s   = {PHY_WIDTH{1'b0}};
        end else begin
          // Strictly greater keeps the earlier (lower) index on equal heights
          if (hit_s && (!best_hit_r || (py_s > best_y_r))) begin
            best_hit_nxt_s = 1'b1;
            best_idx_nxt_s = idx_r;
            best_y_nxt_s   = py_s;
          end else begin
            best_hit_nxt_s = best_hit_r;
          end
          if (idx_r == LAST_IDX) begin
            state_nxt_s = ST_DONE;
            finish_s    = 1'b1;
          end else begin
            idx_nxt_s   = idx_r + 3'd1;
          end
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
        idx_nxt_s   = 3'd0;
      end
    endcase
  end

  // FSM, scan index, latched character and running best-hit registers
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r    <= ST_IDLE;
      idx_r      <= 3'd0;
      cx_r       <= {PHY_WIDTH{1'b0}};
      cy_r       <= {PHY_WIDTH{1'b0}};
      fall_r     <= 1'b0;
      best_hit_r <= 1'b0;
      best_idx_r <= 3'd0;
      best_y_r   <= {PHY_WIDTH{1'b0}};
    end else begin
      state_r    <= state_nxt_s;
      idx_r      <= idx_nxt_s;
      best_hit_r <= best_hit_nxt_s;
      best_idx_r <= best_idx_nxt_s;
      best_y_r   <= best_y_nxt_s;
      if (latch_s) begin
        cx_r   <= char_x;
        cy_r   <= char_y;
        fall_r <= char_falling;
      end
    end
  end

  // Output registers: result is published on the edge that enters DONE
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      busy_r      <= 1'b0;
      scan_done_r <= 1'b0;
      land_hit_r  <= 1'b0;
      land_idx_r  <= 3'd0;
      land_y_r    <= {PHY_WIDTH{1'b0}};
    end else begin
      busy_r      <= (state_nxt_s != ST_IDLE);
      scan_done_r <= finish_s;
      if (finish_s) begin
        land_hit_r <= best_hit_nxt_s;
        if (best_hit_nxt_s) begin
          land_idx_r <= best_idx_nxt_s;
          land_y_r   <= best_y_nxt_s;
        end
      end
    end
  end

  assign busy      = busy_r;
  assign scan_done = scan_done_r;
  assign land_hit  = land_hit_r;
  assign land_idx  = land_idx_r;
  assign land_y    = land_y_r;

endmodule
